// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: round-robin selection among functional units with a
// same-cycle ack and a registered broadcast of the winning result.
package cdb_pkg;
    typedef struct packed {
        logic [31:0] pd_v;
        logic [5:0]  pd;
        logic [4:0]  rob_num;
    } fu_cdb_data_t;
endpackage

module cdb_arbiter
    import cdb_pkg::*;
#(
    parameter int NUM_FU = 4,
    parameter int IDX_W  = $clog2(NUM_FU)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              branch_mispredict,
    input  logic [NUM_FU-1:0] fu_done,
    input  fu_cdb_data_t      fu_data [NUM_FU],
    output logic [NUM_FU-1:0] cdb_ack,
    output logic              cdb_valid,
    output fu_cdb_data_t      cdb_data,
    output logic [IDX_W-1:0]  cdb_src
);

    logic [IDX_W-1:0]  rr_ptr_reg;
    logic [IDX_W-1:0]  rr_ptr_next;
    logic [IDX_W-1:0]  winner;
    logic [NUM_FU-1:0] grant;
    logic              found;

    // Scan from rr_ptr upward with wrap; the first requester encountered wins.
    always_comb begin : arb_search
        int idx;
        idx    = 0;
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        for (int k = 0; k < NUM_FU; k++) begin
            idx = int'(rr_ptr_reg) + k;
            if (idx >= NUM_FU) begin
                idx = idx - NUM_FU;
            end
            if (!found && fu_done[idx]) begin
                found      = 1'b1;
                winner     = IDX_W'(idx);
                grant[idx] = 1'b1;
            end
        end
    end

    assign rr_ptr_next = (winner == IDX_W'(NUM_FU - 1)) ? '0 : winner + 1'b1;

    // A flush or reset suppresses the ack so no squashed result is consumed.
    generate
        for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_ack
            assign cdb_ack[gi] = grant[gi] & ~rst & ~branch_mispredict;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            cdb_valid  <= 1'b0;
            cdb_data   <= '0;
            cdb_src    <= '0;
            rr_ptr_reg <= '0;
        end else if (branch_mispredict) begin
            cdb_valid <= 1'b0;
        end else begin
            cdb_valid <= |cdb_ack;
            if (|cdb_ack) begin
                cdb_data   <= fu_data[winner];
                cdb_src    <= winner;
                rr_ptr_reg <= rr_ptr_next;
            end
        end
    end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: reset, single request, contention, wrap,
// mispredict flush and mid-stream reset, plus per-cycle protocol monitors.
module tb_cdb_arbiter;
    import cdb_pkg::*;

    localparam int NUM_FU = 4;
    localparam int IDX_W  = 2;

    logic              clk;
    logic              rst;
    logic              branch_mispredict;
    logic [NUM_FU-1:0] fu_done;
    fu_cdb_data_t      fu_data [NUM_FU];
    logic [NUM_FU-1:0] cdb_ack;
    logic              cdb_valid;
    fu_cdb_data_t      cdb_data;
    logic [IDX_W-1:0]  cdb_src;

    int checks = 0;
    int errors = 0;

    cdb_arbiter #(.NUM_FU(NUM_FU), .IDX_W(IDX_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .branch_mispredict (branch_mispredict),
        .fu_done           (fu_done),
        .fu_data           (fu_data),
        .cdb_ack           (cdb_ack),
        .cdb_valid         (cdb_valid),
        .cdb_data          (cdb_data),
        .cdb_src           (cdb_src)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic fu_cdb_data_t mk(input logic [31:0] v, input logic [4:0] rob);
        fu_cdb_data_t d;
        d.pd_v    = v;
        d.pd      = rob + 6'd1;
        d.rob_num = rob;
        return d;
    endfunction

    // Inputs change just after posedge; outputs are sampled at the following negedge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Protocol monitor: one-hot ack, ack only to requesters, broadcast matches acked data.
    fu_cdb_data_t sb_data;
    logic         sb_have = 1'b0;
    always @(negedge clk) begin
        if (!rst && !$isunknown(cdb_ack)) begin
            chk("mon_onehot0", 64'($onehot0(cdb_ack)), 64'd1);
            chk("mon_ack_needs_done", 64'(cdb_ack & ~fu_done), 64'd0);
            if (cdb_valid && sb_have) begin
                chk("mon_cdb_data", 64'(cdb_data), 64'(sb_data));
            end
            for (int i = 0; i < NUM_FU; i++) begin
                if (cdb_ack[i]) begin
                    sb_data = fu_data[i];
                    sb_have = 1'b1;
                end
            end
        end
    end

    initial begin
        rst = 1'b1;
        branch_mispredict = 1'b0;
        fu_done = '0;
        for (int i = 0; i < NUM_FU; i++) fu_data[i] = '0;

        // Reset then idle
        for (int c = 0; c < 2; c++) begin
            tick();
            @(negedge clk);
            chk("rst_ack", 64'(cdb_ack), 64'd0);
            chk("rst_valid", 64'(cdb_valid), 64'd0);
            chk("rst_data", 64'(cdb_data), 64'd0);
            chk("rst_src", 64'(cdb_src), 64'd0);
        end
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ack", 64'(cdb_ack), 64'd0);

        // Single FU2 request
        tick();
        fu_done = 4'b0100;
        fu_data[2] = mk(32'h1234, 5'd5);
        @(negedge clk);
        chk("single_ack", 64'(cdb_ack), 64'b0100);
        tick();
        fu_done = 4'b0000;
        @(negedge clk);
        chk("single_valid", 64'(cdb_valid), 64'd1);
        chk("single_src", 64'(cdb_src), 64'd2);
        chk("single_pd_v", 64'(cdb_data.pd_v), 64'h1234);
        chk("single_rob", 64'(cdb_data.rob_num), 64'd5);
        chk("single_ack_drop", 64'(cdb_ack), 64'd0);

        // Wrap from rr_ptr=3: FU0 wins over FU1, then FU1
        tick();
        fu_done = 4'b0011;
        fu_data[0] = mk(32'h0A00, 5'd7);
        fu_data[1] = mk(32'h0B00, 5'd8);
        @(negedge clk);
        chk("wrap_ack0", 64'(cdb_ack), 64'b0001);
        chk("wrap_valid_idle", 64'(cdb_valid), 64'd0);
        tick();
        fu_done = 4'b0010;
        @(negedge clk);
        chk("wrap_ack1", 64'(cdb_ack), 64'b0010);
        chk("wrap_src0", 64'(cdb_src), 64'd0);
        tick();
        fu_done = 4'b0000;
        @(negedge clk);
        chk("wrap_src1", 64'(cdb_src), 64'd1);
        chk("wrap_pd_v1", 64'(cdb_data.pd_v), 64'h0B00);

        // rr_ptr=2: single FU3 request moves rr_ptr back to 0
        tick();
        fu_done = 4'b1000;
        fu_data[3] = mk(32'h0C00, 5'd9);
        @(negedge clk);
        chk("to0_ack3", 64'(cdb_ack), 64'b1000);

        // Full contention from rr_ptr=0: grants 0,1,2,3,0
        tick();
        fu_done = 4'b1111;
        for (int i = 0; i < NUM_FU; i++) fu_data[i] = mk(32'h100 + 32'(i), 5'(i));
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk($sformatf("cont_ack_%0d", k), 64'(cdb_ack), 64'(4'b0001 << (k % 4)));
            chk($sformatf("cont_valid_%0d", k), 64'(cdb_valid), 64'd1);
            chk($sformatf("cont_src_%0d", k), 64'(cdb_src), (k == 0) ? 64'd3 : 64'((k - 1) % 4));
            tick();
            fu_data[k % 4] = mk(32'h200 + 32'(k), 5'(k + 10));
        end

        // Mispredict: FU1 granted at T-1, flush at T with FU0 requesting
        fu_done = 4'b0010;
        @(negedge clk);
        chk("mp_pre_ack", 64'(cdb_ack), 64'b0010);
        tick();
        fu_done = 4'b0001;
        branch_mispredict = 1'b1;
        @(negedge clk);
        chk("mp_ack", 64'(cdb_ack), 64'd0);
        chk("mp_old_valid", 64'(cdb_valid), 64'd1);
        chk("mp_old_src", 64'(cdb_src), 64'd1);
        tick();
        branch_mispredict = 1'b0;
        @(negedge clk);
        chk("mp_valid_cleared", 64'(cdb_valid), 64'd0);
        chk("mp_src_held", 64'(cdb_src), 64'd1);
        chk("mp_regrant", 64'(cdb_ack), 64'b0001);
        tick();
        fu_done = 4'b0000;
        @(negedge clk);
        chk("mp_post_valid", 64'(cdb_valid), 64'd1);
        chk("mp_post_src", 64'(cdb_src), 64'd0);

        // Back-to-back single requester: no bubbles
        tick();
        fu_done = 4'b0100;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("b2b_ack_%0d", k), 64'(cdb_ack), 64'b0100);
            if (k > 0) chk($sformatf("b2b_valid_%0d", k), 64'(cdb_valid), 64'd1);
            tick();
            fu_data[2] = mk(32'h300 + 32'(k), 5'(k + 20));
        end

        // Reset mid-stream under contention (rr_ptr=3 here)
        fu_done = 4'b1111;
        @(negedge clk);
        chk("mr_pre_ack", 64'(cdb_ack), 64'b1000);
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk("mr_ack", 64'(cdb_ack), 64'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mr_valid", 64'(cdb_valid), 64'd0);
        chk("mr_src", 64'(cdb_src), 64'd0);
        chk("mr_data", 64'(cdb_data), 64'd0);
        chk("mr_first_fu0", 64'(cdb_ack), 64'b0001);
        tick();
        fu_done = 4'b0000;
        @(negedge clk);
        chk("mr_post_valid", 64'(cdb_valid), 64'd1);
        chk("mr_post_src", 64'(cdb_src), 64'd0);

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
